// File: rtl/seq_mult.sv
// seq_mult: sequential WIDTH x WIDTH shift-and-add multiplier built around a
// single ripple adder/subtractor (`add`). One multiplier bit is retired per
// clock; a full product takes 16 RUN cycles followed by a one-cycle DONE.
//
// Optional build macro: SEQ_MULT_SIGNED_EN
//   undefined -> unsigned operands/product
//   defined   -> two's complement operands/product
//
// add ports:
//   A, B        addends
//   carry_in    carry in; also selects subtract (B is inverted when set)
//   out         sum
//   carry_out   carry out of the msb
//   overflow    signed overflow of the sum
//
// seq_mult ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request, sampled only when not busy
//   a, b     multiplicand / multiplier, captured on accepted start
//   busy     high while iterating (RUN)
//   done     one-cycle product-valid pulse (DONE)
//   product  result register, held until the next completion

module add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow
);
  // carry_in doubles as the subtract control: A + ~B + 1 == A - B.
  always_comb begin
    logic [WIDTH-1:0] b_x;
    logic             c;
    logic             c_msb;
    b_x   = carry_in ? ~B : B;
    c     = carry_in;
    c_msb = 1'b0;
    out   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH-1) c_msb = c;
      out[i] = A[i] ^ b_x[i] ^ c;
      c      = (A[i] & b_x[i]) | (c & (A[i] ^ b_x[i]));
    end
    carry_out = c;
    // Signed overflow: carry into msb differs from carry out of msb.
    overflow  = c ^ c_msb;
  end
endmodule

module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != 16) begin : g_bad_width
    $error("seq_mult: WIDTH must be 16 to match the add datapath");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   phi_q, phi_d;
  logic [WIDTH-1:0]   plo_q, plo_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   add_b, add_out;
  logic               add_cin, add_co, add_ov;
  logic               msb;
  logic               last;

  assign last  = (cnt_q == 4'd15);
  assign add_b = plo_q[0] ? m_q : '0;

`ifdef SEQ_MULT_SIGNED_EN
  // Final multiplier bit carries negative weight: subtract M instead of add.
  assign add_cin = (state_q == RUN) && last && plo_q[0];
  // True sign of the 17-bit sum, so the shift is arithmetic.
  assign msb     = add_out[WIDTH-1] ^ add_ov;
`else
  assign add_cin = 1'b0;
  assign msb     = add_co;
`endif

  add #(.WIDTH(WIDTH)) u_add (
    .A         (phi_q),
    .B         (add_b),
    .carry_in  (add_cin),
    .out       (add_out),
    .carry_out (add_co),
    .overflow  (add_ov)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          phi_d   = '0;
          plo_d   = b;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        phi_d = {msb, add_out[WIDTH-1:1]};
        plo_d = {add_out[0], plo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          state_d = DONE;
          prod_d  = {phi_d, plo_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_mult.sv
// Directed-vector and random bench for seq_mult. Expected products come from
// a hand-computed table (unsigned or signed column chosen by the build macro
// SEQ_MULT_SIGNED_EN) and from a behavioural multiply for random operands.
module tb_seq_mult;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [15:0] x, input logic [15:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    return 32'($signed(x) * $signed(y));
`else
    return 32'(x) * 32'(y);
`endif
  endfunction

  // One start pulse; returns the product and the number of edges after the
  // accepting edge until done is seen (16 expected). Also checks the pulse
  // is exactly one cycle wide.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                       output logic [31:0] p, output int lat);
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    p = product;
    tick();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] p;
    int          lat;
    logic [15:0] ra, rb;
    int          early;
    int          seen;

    tbl[0] = '{16'h0003, 16'h0005, 32'h0000000F, 32'h0000000F};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h00000001};
    tbl[2] = '{16'h0000, 16'hABCD, 32'h00000000, 32'h00000000};
    tbl[3] = '{16'h8000, 16'h8000, 32'h40000000, 32'h40000000};
    tbl[4] = '{16'h8000, 16'h7FFF, 32'h3FFF8000, 32'hC0008000};
    tbl[5] = '{16'hFFFD, 16'h0007, 32'h0006FFEB, 32'hFFFFFFEB};
    tbl[6] = '{16'h1234, 16'h0010, 32'h00012340, 32'h00012340};
    tbl[7] = '{16'h0001, 16'h8000, 32'h00008000, 32'hFFFF8000};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, p, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd16);
`ifdef SEQ_MULT_SIGNED_EN
      chk($sformatf("vec%0d_product", i), p, tbl[i].exp_s);
`else
      chk($sformatf("vec%0d_product", i), p, tbl[i].exp_u);
`endif
    end

    // Start held through RUN with operands changed mid-run, then a
    // back-to-back accept in the DONE cycle.
    a = 16'h1234; b = 16'h0010; start = 1'b1;
    tick();                      // edge 0
    a = 16'h0002; b = 16'h0003;
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16 && done) early++;
    end
    chk("hs_no_early_done1", 32'(early), 32'd0);
    chk("hs_done1", {31'b0, done}, 32'd1);
    chk("hs_product1", product, 32'h00012340);
    tick();                      // edge 17: second op accepted
    start = 1'b0;
    chk("hs_busy2", {31'b0, busy}, 32'd1);
    chk("hs_done_dropped", {31'b0, done}, 32'd0);
    chk("hs_product_held", product, 32'h00012340);
    early = 0;
    for (int k = 18; k <= 33; k++) begin
      tick();
      if (k < 33 && done) early++;
    end
    chk("hs_no_early_done2", 32'(early), 32'd0);
    chk("hs_done2", {31'b0, done}, 32'd1);
    chk("hs_product2", product, 32'h00000006);
    tick();

    // Reset in the middle of an operation.
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_product", product, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) seen++;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    do_op(16'h00FF, 16'h0101, p, lat);
    chk("rst_after_latency", 32'(lat), 32'd16);
    chk("rst_after_product", p, 32'h0000FFFF);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, p, lat);
      chk("rand_latency", 32'(lat), 32'd16);
      chk($sformatf("rand_%h_%h", ra, rb), p, golden(ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
